// File: rtl/traffic_phase_scheduler_pkg.sv
// traffic_pkg: phase states, default timings and round-robin helper for traffic_phase_scheduler
package traffic_pkg;
  typedef enum logic [1:0] {GREEN, YELLOW, ALLRED, WALK} phase_t;
  localparam int DEF_MIN_GREEN = 8;
  localparam int DEF_MAX_GREEN = 15;
  localparam int DEF_YELLOW_T = 3;
  localparam int DEF_ALLRED_T = 1;
  localparam int DEF_WALK_T = 6;
  function automatic int rr_next(input logic [7:0] pend, input int cur, input int n);
    rr_next = cur;
    for (int i = n; i >= 1; i--)
      if (pend[3'((cur + i) % n)]) rr_next = (cur + i) % n;
  endfunction
endpackage

// File: rtl/traffic_phase_scheduler_if.sv
// traffic_phase_scheduler_if: sensor/lamp bundle; ped_req/walk exist only with TRAFFIC_PED_WALK_EN
interface traffic_phase_scheduler_if #(parameter int N_APPR = 4);
  localparam int AW = $clog2(N_APPR);
  logic [N_APPR-1:0] req, green, yellow, red, pending;
  logic [AW-1:0] cur_appr;
`ifdef TRAFFIC_PED_WALK_EN
  logic ped_req, walk;
  modport master(output req, ped_req, input green, yellow, red, cur_appr, pending, walk);
  modport slave(input req, ped_req, output green, yellow, red, cur_appr, pending, walk);
`else
  modport master(output req, input green, yellow, red, cur_appr, pending);
  modport slave(input req, output green, yellow, red, cur_appr, pending);
`endif
endinterface

// File: rtl/traffic_phase_scheduler_phase_timer.sv
// phase_timer: cycles-in-phase counter with synchronous clear and saturation
module phase_timer #(parameter int TIMER_W = 4) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  output logic [TIMER_W-1:0] count
);
  // count up, hold at all-ones, restart on clear
  always_ff @(posedge clk)
    count <= (rst || clr) ? '0 : (&count) ? count : count + 1'b1;
endmodule

// File: rtl/traffic_phase_scheduler.sv
// traffic_phase_scheduler: round-robin green scheduler with yellow/all-red handover; TRAFFIC_PED_WALK_EN adds a pedestrian WALK phase
module traffic_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int N_APPR    = 4,
  parameter int TIMER_W   = 4,
  parameter int MIN_GREEN = DEF_MIN_GREEN,
  parameter int MAX_GREEN = DEF_MAX_GREEN,
  parameter int YELLOW_T  = DEF_YELLOW_T,
  parameter int ALLRED_T  = DEF_ALLRED_T
`ifdef TRAFFIC_PED_WALK_EN
  , parameter int WALK_T  = DEF_WALK_T
`endif
) (
  input logic clk,
  input logic rst,
  traffic_phase_scheduler_if.slave bus
);
  localparam int AW = $clog2(N_APPR);
  localparam logic [TIMER_W-1:0] MIN_T = TIMER_W'(MIN_GREEN - 1);
  localparam logic [TIMER_W-1:0] MAX_T = TIMER_W'(MAX_GREEN - 1);
  localparam logic [TIMER_W-1:0] YEL_T = TIMER_W'(YELLOW_T - 1);
  localparam logic [TIMER_W-1:0] RED_T = TIMER_W'(ALLRED_T - 1);
  phase_t state, state_nxt;
  logic [AW-1:0] cur_appr, nxt_appr;
  logic [N_APPR-1:0] pending, pend_nxt, one_cur, one_nxt;
  logic [TIMER_W-1:0] timer;
  logic other, leave_green, grant;
  assign one_cur = N_APPR'(1) << cur_appr;
  assign one_nxt = N_APPR'(1) << nxt_appr;
  assign other = |(pending & ~one_cur);
  assign leave_green = timer >= MIN_T && other && (!bus.req[cur_appr] || timer >= MAX_T);
  assign grant = state != GREEN && state_nxt == GREEN;
  assign pend_nxt = (pending | bus.req) & ~(state == GREEN ? one_cur : '0) & ~(grant ? one_nxt : '0);
  phase_timer #(.TIMER_W(TIMER_W)) u_timer (.clk(clk), .rst(rst), .clr(state_nxt != state), .count(timer));
`ifdef TRAFFIC_PED_WALK_EN
  localparam logic [TIMER_W-1:0] WLK_T = TIMER_W'(WALK_T - 1);
  logic ped_pending;
  // latch pedestrian demand, consumed on entry to WALK
  always_ff @(posedge clk)
    if (rst) ped_pending <= 1'b0;
    else ped_pending <= (state_nxt == WALK && state != WALK) ? 1'b0 : ped_pending | bus.ped_req;
  assign bus.walk = state == WALK;
`endif
  // phase sequencing; unknown encodings fall back to all-red clearance
  always_comb begin
    state_nxt = ALLRED;
    case (state)
      GREEN:  state_nxt = leave_green ? YELLOW : GREEN;
      YELLOW: state_nxt = timer >= YEL_T ? ALLRED : YELLOW;
`ifdef TRAFFIC_PED_WALK_EN
      ALLRED: state_nxt = timer >= RED_T ? (ped_pending ? WALK : GREEN) : ALLRED;
      WALK:   state_nxt = timer >= WLK_T ? GREEN : WALK;
`else
      ALLRED: state_nxt = timer >= RED_T ? GREEN : ALLRED;
`endif
      default: state_nxt = ALLRED;
    endcase
  end
  // state, request latch, round-robin pick on green exit, grant on return to green
  always_ff @(posedge clk)
    if (rst) begin
      state <= GREEN;
      cur_appr <= '0;
      nxt_appr <= '0;
      pending <= '0;
    end else begin
      state <= state_nxt;
      pending <= pend_nxt;
      if (state == GREEN && state_nxt == YELLOW) nxt_appr <= AW'(rr_next(8'(pending), int'(cur_appr), N_APPR));
      if (grant) cur_appr <= nxt_appr;
    end
  assign bus.green = state == GREEN ? one_cur : '0;
  assign bus.yellow = state == YELLOW ? one_cur : '0;
  assign bus.red = ~(bus.green | bus.yellow);
  assign bus.cur_appr = cur_appr;
  assign bus.pending = pending;
endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// tb_traffic_phase_scheduler: directed plus random stimulus against a cycle-count reference model with scoreboard
module tb_traffic_phase_scheduler;
  localparam int N = 4;
  localparam int MIN_G = 8;
  localparam int MAX_G = 15;
  localparam int YT = 3;
  localparam int AT = 1;
  typedef struct packed {logic [N-1:0] g, y, r, p; logic [1:0] c;} exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  traffic_phase_scheduler_if #(.N_APPR(N)) bus();
  traffic_phase_scheduler #(.N_APPR(N)) dut(.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  exp_t q[$];
  exp_t e, a;
  int n_chk = 0, n_pass = 0;
  int ph = 0, cur = 0, nxt = 0, el = 0;
  bit [N-1:0] pend = '0;
  // reference: phase 0 green, 1 yellow, 2 all-red; el = cycles completed in phase
  task automatic step(input logic [N-1:0] rq, input bit r);
    bit [N-1:0] np;
    bit others;
    exp_t x;
    @(negedge clk);
    bus.req = rq;
    rst = r;
    if (r) begin
      ph = 0; cur = 0; nxt = 0; el = 0; pend = '0;
    end else begin
      np = pend | rq;
      if (ph == 0) np[cur] = 1'b0;
      el++;
      if (ph == 0) begin
        others = 1'b0;
        for (int j = 0; j < N; j++) if (j != cur && pend[j]) others = 1'b1;
        if (el >= MIN_G && others && (!rq[cur] || el >= MAX_G)) begin
          for (int d = N - 1; d >= 1; d--) if (pend[(cur + d) % N]) nxt = (cur + d) % N;
          ph = 1; el = 0;
        end
      end else if (ph == 1) begin
        if (el == YT) begin ph = 2; el = 0; end
      end else if (el == AT) begin
        ph = 0; el = 0; cur = nxt; np[nxt] = 1'b0;
      end
      pend = np;
    end
    x.g = ph == 0 ? N'(1 << cur) : '0;
    x.y = ph == 1 ? N'(1 << cur) : '0;
    x.r = ~(x.g | x.y);
    x.p = pend;
    x.c = 2'(cur);
    q.push_back(x);
  endtask
  task automatic run_until(input int tph, input int tcur);
    int k = 0;
    while (!(ph == tph && (tcur < 0 || cur == tcur)) && k < 200) begin
      step('0, 1'b0);
      k++;
    end
    n_chk++;
    if (ph == tph && (tcur < 0 || cur == tcur)) n_pass++;
    else $display("FAIL run_until: reached phase=%0d cur=%0d, required phase=%0d cur=%0d", ph, cur, tph, tcur);
  endtask
  // monitor: compare every post-edge output against the oldest expectation
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      a = {bus.green, bus.yellow, bus.red, bus.pending, bus.cur_appr};
      n_chk++;
      if (a === e) n_pass++;
      else $display("FAIL lamps t=%0t: got g=%b y=%b r=%b p=%b c=%0d, want g=%b y=%b r=%b p=%b c=%0d",
                    $time, a.g, a.y, a.r, a.p, a.c, e.g, e.y, e.r, e.p, e.c);
    end
  end
  initial begin
    logic [N-1:0] rq;
    bus.req = '0;
`ifdef TRAFFIC_PED_WALK_EN
    bus.ped_req = 1'b0;
`endif
    step('0, 1'b1);
    step('0, 1'b1);
    repeat (40) step('0, 1'b0);
    @(posedge clk);
    #2;
    n_chk++;
    if (dut.timer === 4'd15) n_pass++;
    else $display("FAIL timer_sat: got %0d, want 15", dut.timer);
    step('0, 1'b1);
    step('0, 1'b0);
    step('0, 1'b0);
    step(4'b0100, 1'b0);
    repeat (20) step('0, 1'b0);
    step('0, 1'b1);
    step(4'b0001, 1'b0);
    step(4'b0011, 1'b0);
    repeat (13) step(4'b0001, 1'b0);
    run_until(0, 1);
    step(4'b1001, 1'b0);
    repeat (50) step('0, 1'b0);
    step('0, 1'b1);
    step('0, 1'b0);
    step(4'b1000, 1'b0);
    run_until(1, -1);
    step(4'b0100, 1'b0);
    repeat (40) step('0, 1'b0);
    step(4'b0010, 1'b0);
    run_until(2, -1);
    step('0, 1'b1);
    repeat (3) step('0, 1'b0);
    repeat (3000) begin
      for (int i = 0; i < N; i++) rq[i] = ($urandom_range(0, 7) == 0);
      step(rq, $urandom_range(0, 599) == 0);
    end
    repeat (3) @(negedge clk);
    n_chk++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d expectations left, want 0", q.size());
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
